// File: rtl/jpeg_fifo_pkg.sv
// Shared defaults for the JPEG skip FIFO and its storage array.
// Holds parameter defaults and pointer-width arithmetic used by both modules.
package jpeg_fifo_pkg;

    localparam int DEF_DATA_W    = 91;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_MAX_SKIP  = 3;
    localparam int DEF_AF_MARGIN = 2;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ff_fifo_mem.sv
// Simple dual-port register array with a registered, enable-gated read port.
// Only the read register is reset; the array itself holds whatever was written.
module ff_fifo_mem
    import jpeg_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately not reset; resetting it would turn
    // plain flops into reset flops for no functional gain, since pointers gate reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jpeg_skip_fifo.sv
// FIFO where each write may reserve up to MAX_SKIP trailing dummy slots.
// Dummy slots read back with rdata_dummy set so the consumer can discard them.
module jpeg_skip_fifo
    import jpeg_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_SKIP  = DEF_MAX_SKIP,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = ptr_width(DEPTH),
    localparam int SW       = $clog2(MAX_SKIP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic [SW-1:0]     skip_count,
    input  logic              read_req,
    output logic [DATA_W-1:0] read_data,
    output logic              rdata_valid,
    output logic              rdata_dummy,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic [PW-1:0]     fifo_count,
    output logic              overflow
);

    logic [PW-1:0]    write_ptr;
    logic [PW-1:0]    read_ptr;
    logic [PW-1:0]    free_slots;
    logic [PW-1:0]    need_slots;
    logic [DEPTH-1:0] dummy_bits;
    logic             wr_accept;
    logic             rd_enable;

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        fifo_count  = write_ptr - read_ptr;
        free_slots  = PW'(DEPTH) - fifo_count;
        need_slots  = PW'(skip_count) + PW'(1);
        fifo_empty  = (fifo_count == '0);
        fifo_full   = (fifo_count == PW'(DEPTH));
        almost_full = (free_slots <= PW'(AF_MARGIN));
        rd_enable   = read_req && !fifo_empty && !flush;
        // Free space is judged on the pre-edge count; a concurrent read earns no credit.
        wr_accept   = write_enable && !flush && (free_slots >= need_slots);
    end

    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_ptr   <= '0;
            read_ptr    <= '0;
            rdata_valid <= 1'b0;
            rdata_dummy <= 1'b0;
            overflow    <= 1'b0;
            dummy_bits  <= '0;
        end else if (flush) begin
            write_ptr   <= '0;
            read_ptr    <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_enable;
            if (rd_enable) begin
                read_ptr    <= read_ptr + PW'(1);
                rdata_dummy <= dummy_bits[read_ptr[AW-1:0]];
            end
            if (write_enable && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                write_ptr <= write_ptr + need_slots;
                dummy_bits[write_ptr[AW-1:0]] <= 1'b0;
                for (int i = 1; i <= MAX_SKIP; i++) begin
                    if (i <= int'(skip_count)) begin
                        dummy_bits[AW'(write_ptr[AW-1:0] + AW'(i))] <= 1'b1;
                    end
                end
            end
        end
    end

    ff_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (write_ptr[AW-1:0]),
        .wr_data (write_data),
        .rd_en   (rd_enable),
        .rd_addr (read_ptr[AW-1:0]),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_jpeg_skip_fifo.sv
// Scoreboard bench for jpeg_skip_fifo: the driver predicts each read into a queue,
// and a negedge monitor pops and compares whenever read data is due.
module tb_jpeg_skip_fifo;
    import jpeg_fifo_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = DEF_DEPTH;
    localparam int MSK   = DEF_MAX_SKIP;
    localparam int AFM   = DEF_AF_MARGIN;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(MSK + 1);

    typedef struct {
        logic [DW-1:0] data;
        bit            dummy;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst, flush, write_enable, read_req;
    logic [DW-1:0] write_data;
    logic [SW-1:0] skip_count;
    logic [DW-1:0] read_data;
    logic          rdata_valid, rdata_dummy;
    logic          fifo_empty, fifo_full, almost_full, overflow;
    logic [PW-1:0] fifo_count;

    entry_t fifo_q[$];
    entry_t exp_q[$];
    entry_t mon_e;
    bit     m_ovf  = 1'b0;
    bit     mon_en = 1'b0;
    int     checks = 0;
    int     errors = 0;

    jpeg_skip_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .write_enable (write_enable),
        .write_data   (write_data),
        .skip_count   (skip_count),
        .read_req     (read_req),
        .read_data    (read_data),
        .rdata_valid  (rdata_valid),
        .rdata_dummy  (rdata_dummy),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per edge on which the model predicted a read.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rdata_valid", rdata_valid, 1);
                check("rdata_dummy", rdata_dummy, mon_e.dummy);
                if (!mon_e.dummy) check("read_data", read_data, mon_e.data);
            end else begin
                check("rdata_valid_idle", rdata_valid, 0);
            end
        end
    end

    // One clock of stimulus; the model is updated from pre-edge state.
    task automatic step(input bit we, input logic [DW-1:0] d, input int sk,
                        input bit rd, input bit fl, input bit rs);
        int cnt;
        bit rd_ok, wr_ok;
        @(negedge clk);
        #1;
        write_enable = we;
        write_data   = d;
        skip_count   = SW'(sk);
        read_req     = rd;
        flush        = fl;
        rst          = rs;
        cnt = fifo_q.size();
        if (rs) begin
            fifo_q.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            fifo_q.delete();
        end else begin
            rd_ok = rd && (cnt > 0);
            wr_ok = we && ((DEPTH - cnt) >= (1 + sk));
            if (we && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) exp_q.push_back(fifo_q.pop_front());
            if (wr_ok) begin
                fifo_q.push_back('{data: d, dummy: 1'b0});
                for (int k = 0; k < sk; k++) fifo_q.push_back('{data: '0, dummy: 1'b1});
            end
        end
        @(posedge clk);
        #1;
        check("fifo_count", fifo_count, fifo_q.size());
        check("fifo_empty", fifo_empty, fifo_q.size() == 0);
        check("fifo_full", fifo_full, fifo_q.size() == DEPTH);
        check("almost_full", almost_full, (DEPTH - fifo_q.size()) <= AFM);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic idle();
        step(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write_enable = 1'b0; read_req = 1'b0;
        write_data = '0; skip_count = '0;

        step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
        check("reset read_data", read_data, 0);
        check("reset rdata_valid", rdata_valid, 0);
        check("reset rdata_dummy", rdata_dummy, 0);
        mon_en = 1'b1;

        // Single word round trip
        step(1'b1, DW'('hA1), 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 0, 1'b1, 1'b0, 1'b0);
        check("a1 empty after read", fifo_empty, 1);
        idle();

        // Skip of two: payload then two dummies
        step(1'b1, DW'('hB0B), 2, 1'b0, 1'b0, 1'b0);
        check("skip2 count", fifo_count, 3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 0, 1'b1, 1'b0, 1'b0);
        idle();

        // Fill to 15, oversize write dropped, exact-fit write fills
        for (int i = 0; i < 15; i++) step(1'b1, DW'(32'h100 + i), 0, 1'b0, 1'b0, 1'b0);
        check("fill15 count", fifo_count, 15);
        step(1'b1, DW'('hDEAD), 1, 1'b0, 1'b0, 1'b0);
        check("drop overflow", overflow, 1);
        check("drop count", fifo_count, 15);
        step(1'b1, DW'('hF00D), 0, 1'b0, 1'b0, 1'b0);
        check("full after fit", fifo_full, 1);

        // Full: concurrent read does not make room for the write
        step(1'b1, DW'('hBAD), 0, 1'b1, 1'b0, 1'b0);
        check("full rw count", fifo_count, 15);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 0, 1'b1, 1'b0, 1'b0);
        check("pre-flush count", fifo_count, 5);
        step(1'b1, DW'('hCAFE), 0, 1'b1, 1'b1, 1'b0);
        check("flush empty", fifo_empty, 1);
        check("flush keeps overflow", overflow, 1);
        idle();

        // Mixed traffic across several pointer wraps
        step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step((i % 4) != 3, DW'(32'h39000 + i), (i * 7) % 4,
                 ((i % 3) == 0) || (i >= 30), 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation discards pending data and the concurrent read
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h5500 + i), 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 0, 1'b1, 1'b0, 1'b1);
        check("midreset read_data", read_data, 0);
        idle();
        idle();

        check("scoreboard drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
